// File: rtl/axi4_write_slave_mem.sv
// AXI4 write-channel responder backed by a byte-writable memory.
// Accepts one AW/W burst at a time (FIXED/INCR/WRAP), applies byte strobes,
// returns one B response per burst, and exposes a combinational peek port.
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   axi_aw*                    write address channel (awready registered)
//   axi_w*                     write data channel (wready registered)
//   axi_b*                     write response channel (all registered)
//   peek_addr / peek_data      combinational memory word read
module axi4_write_slave_mem #(
  parameter int unsigned          DataWidth = 64,
  parameter int unsigned          AddrWidth = 32,
  parameter int unsigned          IdWidth   = 8,
  parameter int unsigned          MemDepth  = 256,
  parameter logic [AddrWidth-1:0] BaseAddr  = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [IdWidth-1:0]          axi_awid,
  input  logic [AddrWidth-1:0]        axi_awaddr,
  input  logic [7:0]                  axi_awlen,
  input  logic [2:0]                  axi_awsize,
  input  logic [1:0]                  axi_awburst,
  input  logic                        axi_awvalid,
  output logic                        axi_awready,
  input  logic [DataWidth-1:0]        axi_wdata,
  input  logic [DataWidth/8-1:0]      axi_wstrb,
  input  logic                        axi_wlast,
  input  logic                        axi_wvalid,
  output logic                        axi_wready,
  output logic [IdWidth-1:0]          axi_bid,
  output logic [1:0]                  axi_bresp,
  output logic                        axi_bvalid,
  input  logic                        axi_bready,
  input  logic [$clog2(MemDepth)-1:0] peek_addr,
  output logic [DataWidth-1:0]        peek_data
);

  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned OffW      = $clog2(StrbWidth);
  localparam int unsigned IdxW      = $clog2(MemDepth);

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlvErr = 2'b10;
  localparam logic [1:0] RespDecErr = 2'b11;

  typedef enum logic [1:0] {IDLE, DATA, RESP} state_e;

  state_e                 state;
  logic [AddrWidth-1:0]   addr_q;
  logic [7:0]             len_q;
  logic [2:0]             size_q;
  logic [1:0]             burst_q;
  logic [7:0]             beat_cnt;
  logic                   dec_err_q;
  logic                   slv_err_q;
  logic                   no_write_q;
  logic [DataWidth-1:0]   mem [MemDepth];

  logic                   aw_hs;
  logic                   w_hs;
  logic                   aw_proto_err;
  logic [AddrWidth-1:0]   offset;
  logic [AddrWidth-1:0]   idx_full;
  logic [IdxW-1:0]        widx;
  logic                   beat_dec;
  logic                   last_beat;
  logic                   wlast_bad;
  logic                   dec_nxt;
  logic                   slv_nxt;
  logic [AddrWidth-1:0]   step;
  logic [AddrWidth-1:0]   wrap_bytes;
  logic [AddrWidth-1:0]   wrap_lo;
  logic [AddrWidth-1:0]   addr_inc;
  logic [AddrWidth-1:0]   addr_nxt;
  logic [DataWidth-1:0]   wmask;

  assign aw_hs = axi_awvalid && axi_awready;
  assign w_hs  = axi_wvalid && axi_wready;

  // Burst-wide protocol errors known from the AW beat alone; such bursts never write.
  assign aw_proto_err = (axi_awsize > 3'(OffW)) ||
                        (axi_awburst == BurstRsvd) ||
                        ((axi_awburst == BurstWrap) &&
                         !((axi_awlen == 8'd1) || (axi_awlen == 8'd3) ||
                           (axi_awlen == 8'd7) || (axi_awlen == 8'd15)));

  // Current beat's word index and decode check.
  assign offset    = addr_q - BaseAddr;
  assign idx_full  = offset >> OffW;
  assign widx      = idx_full[IdxW-1:0];
  assign beat_dec  = (addr_q < BaseAddr) || (idx_full >= AddrWidth'(MemDepth));
  assign last_beat = (beat_cnt == len_q);
  assign wlast_bad = (axi_wlast != last_beat);
  assign dec_nxt   = dec_err_q | beat_dec;
  assign slv_nxt   = slv_err_q | wlast_bad;

  // Next beat address; WRAP folds back to the aligned window base.
  always_comb begin
    step       = AddrWidth'(1) << size_q;
    wrap_bytes = (AddrWidth'(len_q) + AddrWidth'(1)) << size_q;
    wrap_lo    = addr_q & ~(wrap_bytes - AddrWidth'(1));
    addr_inc   = addr_q + step;
    addr_nxt   = addr_inc;
    unique case (burst_q)
      BurstFixed: addr_nxt = addr_q;
      BurstIncr:  addr_nxt = addr_inc;
      BurstWrap:  addr_nxt = (addr_inc == wrap_lo + wrap_bytes) ? wrap_lo : addr_inc;
      default:    addr_nxt = addr_inc;
    endcase
  end

  // Byte strobes expanded to a bit mask.
  for (genvar g = 0; g < StrbWidth; g++) begin : g_mask
    assign wmask[8*g +: 8] = {8{axi_wstrb[g]}};
  end

  // Burst FSM, registered handshake outputs and memory.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      axi_awready <= 1'b0;
      axi_wready  <= 1'b0;
      axi_bvalid  <= 1'b0;
      axi_bid     <= '0;
      axi_bresp   <= RespOkay;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_cnt    <= '0;
      dec_err_q   <= 1'b0;
      slv_err_q   <= 1'b0;
      no_write_q  <= 1'b0;
      mem         <= '{default: '0};
    end else begin
      unique case (state)
        IDLE: begin
          axi_awready <= 1'b1;
          if (aw_hs) begin
            axi_awready <= 1'b0;
            axi_wready  <= 1'b1;
            axi_bid     <= axi_awid;
            addr_q      <= axi_awaddr;
            len_q       <= axi_awlen;
            size_q      <= axi_awsize;
            burst_q     <= axi_awburst;
            beat_cnt    <= '0;
            dec_err_q   <= 1'b0;
            slv_err_q   <= aw_proto_err;
            no_write_q  <= aw_proto_err;
            state       <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (!no_write_q && !beat_dec) begin
              mem[widx] <= (mem[widx] & ~wmask) | (axi_wdata & wmask);
            end
            beat_cnt  <= beat_cnt + 8'd1;
            addr_q    <= addr_nxt;
            dec_err_q <= dec_nxt;
            slv_err_q <= slv_nxt;
            if (last_beat) begin
              axi_wready <= 1'b0;
              axi_bvalid <= 1'b1;
              axi_bresp  <= dec_nxt ? RespDecErr : (slv_nxt ? RespSlvErr : RespOkay);
              state      <= RESP;
            end
          end
        end
        RESP: begin
          if (axi_bvalid && axi_bready) begin
            axi_bvalid  <= 1'b0;
            axi_awready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign peek_data = mem[peek_addr];

endmodule

// File: doc/axi4_write_slave_mem.md
# axi4_write_slave_mem

AXI4 write-channel responder with an internal byte-writable memory. It is the far end of the AW/W/B path that the bridge drives. It accepts AXI4 write bursts (FIXED/INCR/WRAP), applies byte strobes, and returns one B response per burst. A combinational peek port lets the bench check memory contents without a read channel.

## Interface
Parameters:
- DataWidth, 64: W data width in bits; power of two, 8..1024.
- AddrWidth, 32: AW address width.
- IdWidth, 8: AXI ID width.
- MemDepth, 256: number of DataWidth-bit memory words; power of two.
- BaseAddr, 32'h0: byte address that maps to word 0.

Ports:
- clk_i  in  1  clock; all logic on the rising edge.
- rst_ni  in  1  asynchronous, active-low reset.
- axi_awid  in  IdWidth  write ID.
- axi_awaddr  in  AddrWidth  start byte address.
- axi_awlen  in  8  beats minus 1.
- axi_awsize  in  3  log2 of bytes per beat.
- axi_awburst  in  2  00 FIXED, 01 INCR, 10 WRAP, 11 reserved.
- axi_awvalid  in  1  AW valid.
- axi_awready  out  1  AW ready.
- axi_wdata  in  DataWidth  write data.
- axi_wstrb  in  DataWidth/8  byte strobes.
- axi_wlast  in  1  last-beat marker.
- axi_wvalid  in  1  W valid.
- axi_wready  out  1  W ready.
- axi_bid  out  IdWidth  ID echoed from the captured AW.
- axi_bresp  out  2  00 OKAY, 10 SLVERR, 11 DECERR.
- axi_bvalid  out  1  B valid.
- axi_bready  in  1  B ready.
- peek_addr  in  $clog2(MemDepth)  word index.
- peek_data  out  DataWidth  mem[peek_addr], combinational.

## Operation
The FSM has three states: IDLE, DATA and RESP. One burst is outstanding at a time.

- **IDLE:**
  - axi_awready=1.
  - On AW handshake, capture id, addr, len, size and burst; clear beat_cnt and the error flags; go to DATA.
- **DATA:**
  - axi_wready=1 and axi_awready=0.
  - On each W handshake, write every byte lane whose strobe is set to mem[idx], where idx=(addr-BaseAddr)>>log2(DataWidth/8). Lanes are used as presented; the bridge does not re-align narrow beats.
  - Increment beat_cnt and advance addr.
  - When beat_cnt==len on the handshake, go to RESP.
- **RESP:**
  - axi_bvalid=1 and axi_wready=0.
  - axi_bvalid holds, with axi_bid and axi_bresp stable, until axi_bready.
  - On the B handshake, go to IDLE.

Address advance, with byte address arithmetic modulo 2^AddrWidth:
- FIXED: the address is unchanged.
- INCR: addr += 1<<size. There is no 4 KB crossing check.
- WRAP: with wb=(len+1)<<size and lo=addr&~(wb-1), next = (addr+(1<<size)==lo+wb) ? lo : addr+(1<<size).

Error flags are sticky for the burst:
- **dec_err:** set when a beat's addr<BaseAddr or idx>=MemDepth. That beat's write is suppressed; other beats are unaffected.
- **slv_err, protocol errors:** set when any of the following holds:
  - wlast=1 on a beat other than beat len, or wlast=0 on beat len. Data is still written.
  - size>log2(DataWidth/8).
  - burst=11.
  - burst=WRAP with len not in {1,3,7,15}.
- For the size, burst=11 and bad-WRAP-length protocol errors, every beat is consumed and none is written.
- Resulting bresp: DECERR if dec_err, else SLVERR if slv_err, else OKAY.
- The burst always consumes exactly len+1 beats, regardless of wlast.

Reset values:
- axi_awready=0 while rst_ni=0, then 1 in IDLE.
- axi_wready=0, axi_bvalid=0, axi_bid=0, axi_bresp=00.
- All memory words are cleared to 0.

Reset mid-operation: asserting rst_ni asynchronously forces IDLE, the reset output values and a cleared memory. The in-flight burst is discarded and no B response is issued for it.

## Timing
- AW handshake at cycle T. axi_wready=1 from T+1.
- With continuous wvalid, beat k is accepted at T+1+k.
- Last beat at T+1+len. axi_bvalid=1 at T+2+len.
- B handshake at cycle R. axi_awready=1 at R+1.
- Minimum burst period is len+3 cycles.
- A memory write is visible on peek_data in the cycle after its W handshake.
- Gaps in wvalid stall beat_cnt. Nothing else changes during a gap.

## Test plan
- **Single-beat write:** AW id=01, addr=0x10, len=0, size=3, INCR; W data=AABBCCDDEEFF0011, strb=FF, wlast=1 -> B id=01, bresp=00, bvalid at T+2; peek 2 = AABBCCDDEEFF0011.
- **Partial strobe:** then addr=0x10, strb=0F, data=1122334455667788 -> peek 2 = AABBCCDD55667788, bresp=00.
- **INCR burst with gaps:** addr=0x100, len=3, data 1,2,3,4, with one idle cycle between beats -> peek 32..35 = 1,2,3,4; bvalid exactly 1 cycle after beat 4.
- **WRAP burst:** addr=0x218, len=3, size=3, data A,B,C,D -> peek 67=A, 64=B, 65=C, 66=D; bresp=00.
- **Error bursts:**
  - addr=0x7F8, len=1, INCR -> word 255 written, beat 2 (idx 256) dropped, bresp=11.
  - wlast=1 on beat 0 of a len=1 burst -> both beats written, bresp=10.
  - burst=11 -> no writes, bresp=10.
- **Backpressure and reset:**
  - Hold bready=0 for 5 cycles -> bvalid stays 1 with stable bid/bresp, awready stays 0.
  - Assert rst_ni=0 mid-DATA -> wready=0 and bvalid=0 immediately; all peeks read 0; the next AW is accepted after release.
